// File: rtl/rd_req_arb.sv
// rd_req_arb: shares the mem_rd DMA-read engine between the RX-buffer fetch
// path (r0) and the descriptor fetch path (r1). Owns the PCIe read-tag pool,
// caps outstanding reads at MX_OS_RQ and records which requester owns each
// tag so the completion path can route returning data.
module rd_req_arb #(
  parameter int MX_OS_RQ = 4,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_rd,
  input  logic [63:0]      r0_hst_addr,
  input  logic [8:0]       r0_rd_qw,
  output logic             r0_rd_ack,
  output logic [TAG_W-1:0] r0_rd_tag,
  input  logic             r1_rd,
  input  logic [63:0]      r1_hst_addr,
  input  logic [8:0]       r1_rd_qw,
  output logic             r1_rd_ack,
  output logic [TAG_W-1:0] r1_rd_tag,
  output logic             mrd_rd,
  output logic [63:0]      mrd_hst_addr,
  output logic [8:0]       mrd_rd_qw,
  output logic [TAG_W-1:0] mrd_rd_tag,
  input  logic             mrd_rd_ack,
  input  logic             cpl_dn,
  input  logic [TAG_W-1:0] cpl_tag,
  input  logic [TAG_W-1:0] lkp_tag,
  output logic             lkp_owner,
  output logic [5:0]       os_cnt,
  output logic             tag_err
);

  localparam logic [5:0] MAX_OS = 6'(MX_OS_RQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD1 = 2'd2,
    ST_HOLD2 = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [MX_OS_RQ-1:0]   busy_q, busy_d;
  logic [MX_OS_RQ-1:0]   owner_q, owner_d;
  logic [5:0]            os_cnt_q, os_cnt_d;
  logic                  rr_q, rr_d;          // 0: r0 wins a tie next, 1: r1
  logic                  win_q, win_d;        // requester of the read in flight
  logic                  mrd_rd_q, mrd_rd_d;
  logic [63:0]           mrd_addr_q, mrd_addr_d;
  logic [8:0]            mrd_qw_q, mrd_qw_d;
  logic [TAG_W-1:0]      mrd_tag_q, mrd_tag_d;
  logic                  r0_ack_q, r0_ack_d;
  logic                  r1_ack_q, r1_ack_d;
  logic [TAG_W-1:0]      r0_tag_q, r0_tag_d;
  logic [TAG_W-1:0]      r1_tag_q, r1_tag_d;
  logic                  tag_err_q, tag_err_d;

  logic [MX_OS_RQ-1:0]   rel_vec_s;
  logic                  rel_hit_s;
  logic [MX_OS_RQ-1:0]   free_vec_s;
  logic [TAG_W-1:0]      free_tag_s;
  logic [MX_OS_RQ-1:0]   alloc_vec_s;
  logic                  alloc_s;
  logic                  gnt_s;
  logic                  lkp_owner_s;

  // Decode a completion release; only a currently busy in-range tag matches.
  always_comb begin
    rel_vec_s = {MX_OS_RQ{1'b0}};
    for (int i = 0; i < MX_OS_RQ; i++) begin
      rel_vec_s[i] = cpl_dn & (cpl_tag == TAG_W'(i)) & busy_q[i];
    end
    rel_hit_s = |rel_vec_s;
  end

  // Find the lowest-index free tag (scan downwards so the lowest one wins).
  always_comb begin
    free_tag_s = {TAG_W{1'b0}};
    free_vec_s = {MX_OS_RQ{1'b0}};
    for (int i = MX_OS_RQ - 1; i >= 0; i--) begin
      free_tag_s = busy_q[i] ? free_tag_s : TAG_W'(i);
    end
    for (int i = 0; i < MX_OS_RQ; i++) begin
      free_vec_s[i] = ~busy_q[i] & (free_tag_s == TAG_W'(i));
    end
  end

  // Combinational owner lookup for the completion path.
  always_comb begin
    lkp_owner_s = 1'b0;
    for (int i = 0; i < MX_OS_RQ; i++) begin
      lkp_owner_s = lkp_owner_s | (owner_q[i] & (lkp_tag == TAG_W'(i)));
    end
  end

  // Arbitration FSM: grant in IDLE, wait for mem_rd in ISSUE, then hold off 2 cycles.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    win_d      = win_q;
    mrd_rd_d   = mrd_rd_q;
    mrd_addr_d = mrd_addr_q;
    mrd_qw_d   = mrd_qw_q;
    mrd_tag_d  = mrd_tag_q;
    r0_ack_d   = 1'b0;
    r1_ack_d   = 1'b0;
    r0_tag_d   = r0_tag_q;
    r1_tag_d   = r1_tag_q;
    alloc_s    = 1'b0;
    gnt_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Fullness uses the registered count: a tag freed this cycle is usable next cycle.
        if ((r0_rd | r1_rd) && (os_cnt_q < MAX_OS)) begin
          if (r0_rd && r1_rd) begin
            gnt_s = rr_q;
            rr_d  = ~rr_q;
          end else begin
            gnt_s = r1_rd;
          end
          win_d      = gnt_s;
          mrd_addr_d = gnt_s ? r1_hst_addr : r0_hst_addr;
          mrd_qw_d   = gnt_s ? r1_rd_qw : r0_rd_qw;
          mrd_tag_d  = free_tag_s;
          mrd_rd_d   = 1'b1;
          alloc_s    = 1'b1;
          state_d    = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mrd_rd_ack) begin
          mrd_rd_d = 1'b0;
          if (win_q) begin
            r1_ack_d = 1'b1;
            r1_tag_d = mrd_tag_q;
          end else begin
            r0_ack_d = 1'b1;
            r0_tag_d = mrd_tag_q;
          end
          state_d = ST_HOLD1;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_HOLD1: state_d = ST_HOLD2;
      ST_HOLD2: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Tag pool bookkeeping: apply allocation and release together.
  always_comb begin
    alloc_vec_s = alloc_s ? free_vec_s : {MX_OS_RQ{1'b0}};
    busy_d      = (busy_q | alloc_vec_s) & ~rel_vec_s;
    owner_d     = owner_q;
    for (int i = 0; i < MX_OS_RQ; i++) begin
      owner_d[i] = alloc_vec_s[i] ? gnt_s : owner_q[i];
    end
    os_cnt_d  = os_cnt_q + {5'd0, alloc_s} - {5'd0, rel_hit_s};
    tag_err_d = tag_err_q | (cpl_dn & ~rel_hit_s);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= {MX_OS_RQ{1'b0}};
      owner_q    <= {MX_OS_RQ{1'b0}};
      os_cnt_q   <= 6'd0;
      rr_q       <= 1'b0;
      win_q      <= 1'b0;
      mrd_rd_q   <= 1'b0;
      mrd_addr_q <= 64'd0;
      mrd_qw_q   <= 9'd0;
      mrd_tag_q  <= {TAG_W{1'b0}};
      r0_ack_q   <= 1'b0;
      r1_ack_q   <= 1'b0;
      r0_tag_q   <= {TAG_W{1'b0}};
      r1_tag_q   <= {TAG_W{1'b0}};
      tag_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      owner_q    <= owner_d;
      os_cnt_q   <= os_cnt_d;
      rr_q       <= rr_d;
      win_q      <= win_d;
      mrd_rd_q   <= mrd_rd_d;
      mrd_addr_q <= mrd_addr_d;
      mrd_qw_q   <= mrd_qw_d;
      mrd_tag_q  <= mrd_tag_d;
      r0_ack_q   <= r0_ack_d;
      r1_ack_q   <= r1_ack_d;
      r0_tag_q   <= r0_tag_d;
      r1_tag_q   <= r1_tag_d;
      tag_err_q  <= tag_err_d;
    end
  end

  assign mrd_rd       = mrd_rd_q;
  assign mrd_hst_addr = mrd_addr_q;
  assign mrd_rd_qw    = mrd_qw_q;
  assign mrd_rd_tag   = mrd_tag_q;
  assign r0_rd_ack    = r0_ack_q;
  assign r0_rd_tag    = r0_tag_q;
  assign r1_rd_ack    = r1_ack_q;
  assign r1_rd_tag    = r1_tag_q;
  assign os_cnt       = os_cnt_q;
  assign tag_err      = tag_err_q;
  assign lkp_owner    = lkp_owner_s;

endmodule

// File: tb/tb_rd_req_arb.sv
// tb_rd_req_arb: directed bench for rd_req_arb with a transaction-level model
// compared every cycle, plus hand-computed literal expectations.
module tb_rd_req_arb;

  localparam int MX = 4;
  localparam int TW = 5;

  logic          clk;
  logic          rst;
  logic          r0_rd, r1_rd;
  logic [63:0]   r0_hst_addr, r1_hst_addr;
  logic [8:0]    r0_rd_qw, r1_rd_qw;
  logic          r0_rd_ack, r1_rd_ack;
  logic [TW-1:0] r0_rd_tag, r1_rd_tag;
  logic          mrd_rd;
  logic [63:0]   mrd_hst_addr;
  logic [8:0]    mrd_rd_qw;
  logic [TW-1:0] mrd_rd_tag;
  logic          mrd_rd_ack = 1'b0;
  logic          cpl_dn;
  logic [TW-1:0] cpl_tag, lkp_tag;
  logic          lkp_owner;
  logic [5:0]    os_cnt;
  logic          tag_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;
  int hi_cnt    = 0;

  rd_req_arb #(.MX_OS_RQ(MX), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .r0_rd(r0_rd), .r0_hst_addr(r0_hst_addr), .r0_rd_qw(r0_rd_qw),
    .r0_rd_ack(r0_rd_ack), .r0_rd_tag(r0_rd_tag),
    .r1_rd(r1_rd), .r1_hst_addr(r1_hst_addr), .r1_rd_qw(r1_rd_qw),
    .r1_rd_ack(r1_rd_ack), .r1_rd_tag(r1_rd_tag),
    .mrd_rd(mrd_rd), .mrd_hst_addr(mrd_hst_addr), .mrd_rd_qw(mrd_rd_qw),
    .mrd_rd_tag(mrd_rd_tag), .mrd_rd_ack(mrd_rd_ack),
    .cpl_dn(cpl_dn), .cpl_tag(cpl_tag), .lkp_tag(lkp_tag),
    .lkp_owner(lkp_owner), .os_cnt(os_cnt), .tag_err(tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // mem_rd responder: accepts after ack_delay cycles of mrd_rd being high.
  always @(negedge clk) begin
    if (mrd_rd === 1'b1) begin
      mrd_rd_ack = (hi_cnt >= ack_delay);
      hi_cnt++;
    end else begin
      mrd_rd_ack = 1'b0;
      hi_cnt = 0;
    end
  end

  // ---------------- behavioural model ----------------
  bit          m_busy[MX];
  bit          m_owner[MX];
  int          m_ptr;
  bit          m_wait;
  int          m_cool;
  bit          m_win;
  logic [63:0] m_addr;
  logic [8:0]  m_qw;
  logic [4:0]  m_tag;
  bit          m_err;
  bit          m_ack0, m_ack1;
  logic [4:0]  m_t0, m_t1;
  bit          m_rst;

  // Model update on each edge, then compare one time unit later.
  always @(posedge clk) begin
    int cnt;
    int ci;
    int li;
    int who;
    int ft;
    bit rel_ok;
    m_rst = rst;
    if (rst) begin
      for (int i = 0; i < MX; i++) begin m_busy[i] = 0; m_owner[i] = 0; end
      m_ptr = 0; m_wait = 0; m_cool = 0; m_win = 0;
      m_addr = 64'd0; m_qw = 9'd0; m_tag = 5'd0; m_err = 0;
      m_ack0 = 0; m_ack1 = 0; m_t0 = 5'd0; m_t1 = 5'd0;
    end else begin
      cnt = 0;
      for (int i = 0; i < MX; i++) cnt += int'(m_busy[i]);
      ci = int'(cpl_tag);
      rel_ok = 0;
      if (ci < MX) rel_ok = m_busy[ci];
      m_ack0 = 0;
      m_ack1 = 0;
      if (m_wait) begin
        if (mrd_rd_ack) begin
          m_wait = 0;
          m_cool = 2;
          if (m_win) begin m_ack1 = 1; m_t1 = m_tag; end
          else begin m_ack0 = 1; m_t0 = m_tag; end
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if ((r0_rd || r1_rd) && cnt < MX) begin
        if (r0_rd && r1_rd) begin who = m_ptr; m_ptr = 1 - m_ptr; end
        else who = r1_rd ? 1 : 0;
        ft = 0;
        for (int i = MX - 1; i >= 0; i--) if (!m_busy[i]) ft = i;
        m_busy[ft] = 1;
        m_owner[ft] = (who == 1);
        m_win  = (who == 1);
        m_tag  = 5'(ft);
        m_addr = (who == 1) ? r1_hst_addr : r0_hst_addr;
        m_qw   = (who == 1) ? r1_rd_qw : r0_rd_qw;
        m_wait = 1;
      end
      if (cpl_dn) begin
        if (rel_ok) m_busy[ci] = 0;
        else m_err = 1;
      end
    end
    #1;
    cnt = 0;
    for (int i = 0; i < MX; i++) cnt += int'(m_busy[i]);
    check("mdl_mrd_rd", mrd_rd, m_wait);
    check("mdl_r0_ack", r0_rd_ack, m_ack0);
    check("mdl_r1_ack", r1_rd_ack, m_ack1);
    check("mdl_os_cnt", os_cnt, cnt);
    check("mdl_tag_err", tag_err, m_err);
    if (m_wait || m_rst) begin
      check("mdl_mrd_addr", mrd_hst_addr, m_addr);
      check("mdl_mrd_qw", mrd_rd_qw, m_qw);
      check("mdl_mrd_tag", mrd_rd_tag, m_tag);
    end
    if (m_ack0 || m_rst) check("mdl_r0_tag", r0_rd_tag, m_t0);
    if (m_ack1 || m_rst) check("mdl_r1_tag", r1_rd_tag, m_t1);
    li = int'(lkp_tag);
    if (li < MX && m_busy[li]) check("mdl_lkp_owner", lkp_owner, m_owner[li]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_any_ack(input int budget, output int who, output int tag);
    bit seen;
    seen = 0; who = -1; tag = -1;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge clk); #1;
      if (r0_rd_ack) begin seen = 1; who = 0; tag = int'(r0_rd_tag); end
      else if (r1_rd_ack) begin seen = 1; who = 1; tag = int'(r1_rd_tag); end
    end
    check("ack_seen", seen, 1);
  endtask

  task automatic wait_mrd(input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge clk); #1;
      if (mrd_rd) seen = 1;
    end
    check("mrd_seen", seen, 1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int who, tag, nack;
    int exp_who[4];
    int exp_tag[4];
    exp_who = '{0, 1, 0, 1};
    exp_tag = '{0, 1, 2, 3};
    rst = 1'b1; r0_rd = 1'b0; r1_rd = 1'b0;
    r0_hst_addr = 64'd0; r1_hst_addr = 64'd0; r0_rd_qw = 9'd0; r1_rd_qw = 9'd0;
    cpl_dn = 1'b0; cpl_tag = 5'd0; lkp_tag = 5'd0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_mrd_rd", mrd_rd, 0);
    check("rst_acks", {r0_rd_ack, r1_rd_ack}, 0);
    check("rst_os_cnt", os_cnt, 0);
    check("rst_tag_err", tag_err, 0);
    check("rst_mrd_addr", mrd_hst_addr, 0);
    check("rst_mrd_qw_tag", {mrd_rd_qw, mrd_rd_tag, r0_rd_tag, r1_rd_tag}, 0);
    @(negedge clk) rst = 1'b0;

    // Single r0 request with immediate ack
    @(negedge clk);
    r0_rd = 1'b1; r0_hst_addr = 64'h1000; r0_rd_qw = 9'h20;
    @(posedge clk); #1;
    check("t1_mrd_rd", mrd_rd, 1);
    check("t1_mrd_tag", mrd_rd_tag, 0);
    check("t1_mrd_addr", mrd_hst_addr, 64'h1000);
    check("t1_mrd_qw", mrd_rd_qw, 9'h20);
    wait_any_ack(8, who, tag);
    r0_rd = 1'b0;
    check("t1_who", who, 0);
    check("t1_tag", tag, 0);
    check("t1_os_cnt", os_cnt, 1);
    check("t1_lkp_owner", lkp_owner, 0);
    @(posedge clk); #1;
    check("t1_ack_pulse", r0_rd_ack, 0);

    // Release tag 0, then both requesters held: r0,r1,r0,r1 with tags 0..3
    @(negedge clk); cpl_dn = 1'b1; cpl_tag = 5'd0;
    @(negedge clk); cpl_dn = 1'b0;
    r0_rd = 1'b1; r0_hst_addr = 64'h2000; r0_rd_qw = 9'h10;
    r1_rd = 1'b1; r1_hst_addr = 64'h3000; r1_rd_qw = 9'h08;
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(20, who, tag);
      check($sformatf("t2_who%0d", k), who, exp_who[k]);
      check($sformatf("t2_tag%0d", k), tag, exp_tag[k]);
    end
    lkp_tag = 5'd1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("t2_full_no_rd", mrd_rd, 0);
      check("t2_full_cnt", os_cnt, 4);
    end
    check("t2_lkp1", lkp_owner, 1);
    lkp_tag = 5'd2;
    #1;
    check("t2_lkp2", lkp_owner, 0);

    // Release tag 2 while full and r1 pending
    @(negedge clk);
    r0_rd = 1'b0; cpl_dn = 1'b1; cpl_tag = 5'd2;
    @(posedge clk); #1;
    check("t3_cnt_after_rel", os_cnt, 3);
    check("t3_no_rd_yet", mrd_rd, 0);
    @(negedge clk); cpl_dn = 1'b0;
    @(posedge clk); #1;
    check("t3_mrd_rd", mrd_rd, 1);
    check("t3_tag", mrd_rd_tag, 2);
    check("t3_cnt_full", os_cnt, 4);
    wait_any_ack(8, who, tag);
    r1_rd = 1'b0;
    check("t3_who", who, 1);
    check("t3_ack_tag", tag, 2);

    // Free every tag
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); cpl_dn = 1'b1; cpl_tag = 5'(t);
    end
    @(negedge clk); cpl_dn = 1'b0;
    @(posedge clk); #1;
    check("free_all_cnt", os_cnt, 0);
    check("free_all_err", tag_err, 0);

    // Delayed mem_rd ack: fields stable, one ack pulse
    ack_delay = 7;
    @(negedge clk);
    r0_rd = 1'b1; r0_hst_addr = 64'hABCD_0000_1234_5678; r0_rd_qw = 9'h100;
    wait_mrd(8);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      check("t4_hold_rd", mrd_rd, 1);
      check("t4_hold_addr", mrd_hst_addr, 64'hABCD_0000_1234_5678);
      check("t4_hold_qw", mrd_rd_qw, 9'h100);
      check("t4_hold_tag", mrd_rd_tag, 0);
      check("t4_no_ack", {r0_rd_ack, r1_rd_ack}, 0);
    end
    nack = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (r0_rd_ack || r1_rd_ack) begin nack++; r0_rd = 1'b0; end
    end
    check("t4_one_ack", nack, 1);
    ack_delay = 0;

    // Bad releases: free tag 3, then out-of-range tag 9
    @(negedge clk); cpl_dn = 1'b1; cpl_tag = 5'd3;
    @(posedge clk); #1;
    check("t5_err_free", tag_err, 1);
    check("t5_cnt_a", os_cnt, 1);
    @(negedge clk); cpl_tag = 5'd9;
    @(posedge clk); #1;
    check("t5_err_range", tag_err, 1);
    check("t5_cnt_b", os_cnt, 1);
    @(negedge clk); cpl_dn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_err_sticky", tag_err, 1);

    // Reset during ISSUE with two tags busy
    ack_delay = 20;
    lkp_tag = 5'd1;
    @(negedge clk);
    r1_rd = 1'b1; r1_hst_addr = 64'h5000; r1_rd_qw = 9'h4;
    wait_mrd(8);
    check("t6_cnt2", os_cnt, 2);
    check("t6_tag1", mrd_rd_tag, 1);
    check("t6_lkp1", lkp_owner, 1);
    @(negedge clk); rst = 1'b1; r1_rd = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_rd", mrd_rd, 0);
    check("t6_rst_cnt", os_cnt, 0);
    check("t6_rst_err", tag_err, 0);
    @(negedge clk); rst = 1'b0;
    nack = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (r0_rd_ack || r1_rd_ack || mrd_rd) nack++;
    end
    check("t6_no_ack", nack, 0);
    ack_delay = 0;
    @(negedge clk);
    r0_rd = 1'b1; r0_hst_addr = 64'h6000; r0_rd_qw = 9'h1;
    wait_any_ack(8, who, tag);
    r0_rd = 1'b0;
    check("t6_who", who, 0);
    check("t6_tag", tag, 0);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
